// File: rtl/odd_seq_checker_if.sv
// Sample bus feeding the odd-count stream checker.
// The producer drives i_valid/i_count; the checker only observes.
interface odd_seq_checker_if #(
   parameter int WIDTH = 8
);
   logic             i_valid;
   logic [WIDTH-1:0] i_count;

   modport master (output i_valid, output i_count);
   modport slave  (input  i_valid, input  i_count);
endinterface

// File: rtl/odd_seq_checker.sv
// Receive-side monitor for an odd-number count stream.
// Acquires lock on consistent +2 samples, flags breaks and even values.
module odd_seq_checker #(
   parameter int WIDTH     = 8,
   parameter int LOCK_CNT  = 4,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_clear,
   odd_seq_checker_if.slave     smp,
   output logic                 o_locked,
   output logic                 o_err,
   output logic                 o_err_sticky,
   output logic [ERR_CNT_W-1:0] o_err_count,
   output logic [WIDTH-1:0]     o_expected
);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [7:0] LOCK8 = 8'(LOCK_CNT);

   state_t               state_q, state_d;
   logic [7:0]           run_q, run_d;
   logic [WIDTH-1:0]     exp_q, exp_d;
   logic                 locked_q, locked_d;
   logic                 err_q, err_d;
   logic                 sticky_q, sticky_d;
   logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH-1:0]     nxt;
   logic [7:0]           run_inc;
   logic                 hit;
   logic                 odd;
   logic                 bad;

   // Next-state: lock acquisition, resync and error accounting
   always_comb begin
      state_d  = state_q;
      run_d    = run_q;
      exp_d    = exp_q;
      err_d    = 1'b0;
      sticky_d = sticky_q;
      cnt_d    = cnt_q;
      bad      = 1'b0;
      nxt      = smp.i_count + WIDTH'(2);
      run_inc  = run_q + 8'd1;
      hit      = (smp.i_count == exp_q);
      odd      = smp.i_count[0];

      if (i_clear) begin
         state_d  = SEARCH;
         run_d    = 8'd0;
         exp_d    = '0;
         sticky_d = 1'b0;
         cnt_d    = '0;
      end else if (smp.i_valid) begin
         unique case (state_q)
            SEARCH: begin
               if (odd) begin
                  exp_d   = nxt;
                  run_d   = 8'd1;
                  state_d = (LOCK_CNT == 1) ? LOCKED : VERIFY;
               end else begin
                  bad = 1'b1;
               end
            end
            VERIFY: begin
               if (hit) begin
                  exp_d = nxt;
                  run_d = run_inc;
                  if (run_inc == LOCK8) state_d = LOCKED;
               end else if (odd) begin
                  exp_d = nxt;
                  run_d = 8'd1;
               end else begin
                  bad     = 1'b1;
                  state_d = SEARCH;
                  run_d   = 8'd0;
               end
            end
            LOCKED: begin
               if (hit) begin
                  exp_d = nxt;
               end else if (odd) begin
                  bad     = 1'b1;
                  exp_d   = nxt;
                  run_d   = 8'd1;
                  state_d = (LOCK_CNT == 1) ? LOCKED : VERIFY;
               end else begin
                  bad     = 1'b1;
                  state_d = SEARCH;
                  run_d   = 8'd0;
               end
            end
            default: begin
               state_d = SEARCH;
               run_d   = 8'd0;
            end
         endcase

         if (bad) begin
            err_d    = 1'b1;
            sticky_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + ERR_CNT_W'(1);
         end
      end

      locked_d = (state_d == LOCKED);
   end

   // State and registered outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= SEARCH;
         run_q    <= 8'd0;
         exp_q    <= '0;
         locked_q <= 1'b0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         run_q    <= run_d;
         exp_q    <= exp_d;
         locked_q <= locked_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign o_locked     = locked_q;
   assign o_err        = err_q;
   assign o_err_sticky = sticky_q;
   assign o_err_count  = cnt_q;
   assign o_expected   = exp_q;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Directed bench for odd_seq_checker: vector table plus
// hand sequences for saturation, LOCK_CNT=1 and async reset.
module tb_odd_seq_checker;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic clr_a, clr_b, clr_c;

   odd_seq_checker_if #(.WIDTH(8)) if_a ();
   odd_seq_checker_if #(.WIDTH(8)) if_b ();
   odd_seq_checker_if #(.WIDTH(8)) if_c ();

   logic       lk_a, er_a, st_a;
   logic [7:0] ec_a, ex_a;
   logic       lk_b, er_b, st_b;
   logic [1:0] ec_b;
   logic [7:0] ex_b;
   logic       lk_c, er_c, st_c;
   logic [7:0] ec_c, ex_c;

   odd_seq_checker #(.WIDTH(8), .LOCK_CNT(4), .ERR_CNT_W(8)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr_a), .smp(if_a.slave),
      .o_locked(lk_a), .o_err(er_a), .o_err_sticky(st_a),
      .o_err_count(ec_a), .o_expected(ex_a));

   odd_seq_checker #(.WIDTH(8), .LOCK_CNT(4), .ERR_CNT_W(2)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr_b), .smp(if_b.slave),
      .o_locked(lk_b), .o_err(er_b), .o_err_sticky(st_b),
      .o_err_count(ec_b), .o_expected(ex_b));

   odd_seq_checker #(.WIDTH(8), .LOCK_CNT(1), .ERR_CNT_W(8)) dut_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr_c), .smp(if_c.slave),
      .o_locked(lk_c), .o_err(er_c), .o_err_sticky(st_c),
      .o_err_count(ec_c), .o_expected(ex_c));

   typedef struct {
      logic       clr;
      logic       v;
      logic [7:0] cnt;
      logic       e_lk;
      logic       e_er;
      logic       e_st;
      logic [7:0] e_ec;
      logic [7:0] e_ex;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void add(logic clr, logic v, logic [7:0] cnt,
                               logic lk, logic er, logic st,
                               logic [7:0] ec, logic [7:0] ex);
      vec_t r;
      r.clr = clr; r.v = v; r.cnt = cnt;
      r.e_lk = lk; r.e_er = er; r.e_st = st; r.e_ec = ec; r.e_ex = ex;
      tbl.push_back(r);
   endfunction

   task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s[%0d] got %0h want %0h", nm, idx, act, req);
      end
   endtask

   task automatic run_row(vec_t r, int idx);
      @(negedge clk);
      clr_a = r.clr;
      if_a.i_valid = r.v;
      if_a.i_count = r.cnt;
      @(posedge clk);
      #1;
      chk("locked", idx, 32'(lk_a), 32'(r.e_lk));
      chk("err", idx, 32'(er_a), 32'(r.e_er));
      chk("sticky", idx, 32'(st_a), 32'(r.e_st));
      chk("errcnt", idx, 32'(ec_a), 32'(r.e_ec));
      chk("expected", idx, 32'(ex_a), 32'(r.e_ex));
   endtask

   task automatic row(logic clr, logic v, logic [7:0] cnt, logic lk,
                      logic er, logic st, logic [7:0] ec, logic [7:0] ex,
                      int idx);
      vec_t r;
      r.clr = clr; r.v = v; r.cnt = cnt;
      r.e_lk = lk; r.e_er = er; r.e_st = st; r.e_ec = ec; r.e_ex = ex;
      run_row(r, idx);
   endtask

   initial begin
      clr_a = 0; clr_b = 0; clr_c = 0;
      if_a.i_valid = 0; if_a.i_count = 0;
      if_b.i_valid = 0; if_b.i_count = 0;
      if_c.i_valid = 0; if_c.i_count = 0;

      // lock on 1,3,5,7
      add(0,1,  1, 0,0,0,0,  3);
      add(0,1,  3, 0,0,0,0,  5);
      add(0,1,  5, 0,0,0,0,  7);
      add(0,1,  7, 1,0,0,0,  9);
      add(0,0,  0, 1,0,0,0,  9);
      // locked break by odd 11, relock on 13,15,17
      add(0,1, 11, 0,1,1,1, 13);
      add(0,1, 13, 0,0,1,1, 15);
      add(0,1, 15, 0,0,1,1, 17);
      add(0,1, 17, 1,0,1,1, 19);
      // clear beats same-cycle sample
      add(1,1,  9, 0,0,0,0,  0);
      // even in SEARCH
      add(0,1,  4, 0,1,1,1,  0);
      add(0,0,  0, 0,0,1,1,  0);
      // lock, then even while locked
      add(0,1,  1, 0,0,1,1,  3);
      add(0,1,  3, 0,0,1,1,  5);
      add(0,1,  5, 0,0,1,1,  7);
      add(0,1,  7, 1,0,1,1,  9);
      add(0,1,  8, 0,1,1,2,  9);
      // wrap through 255 -> 1
      add(1,0,  0, 0,0,0,0,  0);
      add(0,1,249, 0,0,0,0,251);
      add(0,1,251, 0,0,0,0,253);
      add(0,1,253, 0,0,0,0,255);
      add(0,1,255, 1,0,0,0,  1);
      add(0,1,  1, 1,0,0,0,  3);
      add(0,1,  3, 1,0,0,0,  5);
      // odd mismatch in VERIFY resyncs silently
      add(1,0,  0, 0,0,0,0,  0);
      add(0,1,  1, 0,0,0,0,  3);
      add(0,1,  3, 0,0,0,0,  5);
      add(0,1,  9, 0,0,0,0, 11);
      add(0,1, 11, 0,0,0,0, 13);
      add(0,1, 13, 0,0,0,0, 15);
      add(0,1, 15, 1,0,0,0, 17);
      // even in VERIFY drops to SEARCH
      add(1,0,  0, 0,0,0,0,  0);
      add(0,1,  1, 0,0,0,0,  3);
      add(0,1,  6, 0,1,1,1,  3);
      add(0,1,  3, 0,0,1,1,  5);

      #12 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_locked", 0, 32'(lk_a), 0);
      chk("rst_err", 0, 32'(er_a), 0);
      chk("rst_sticky", 0, 32'(st_a), 0);
      chk("rst_errcnt", 0, 32'(ec_a), 0);
      chk("rst_expected", 0, 32'(ex_a), 0);

      foreach (tbl[i]) run_row(tbl[i], i);

      // async reset mid-VERIFY
      row(1,0,0, 0,0,0,0,0, 100);
      row(0,1,1, 0,0,0,0,3, 101);
      row(0,1,3, 0,0,0,0,5, 102);
      @(negedge clk);
      clr_a = 0; if_a.i_valid = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_expected", 0, 32'(ex_a), 0);
      chk("arst_locked", 0, 32'(lk_a), 0);
      @(negedge clk);
      rst_n = 1'b1;
      row(0,1,1, 0,0,0,0,3, 103);
      row(0,1,3, 0,0,0,0,5, 104);
      row(0,1,5, 0,0,0,0,7, 105);
      row(0,1,7, 1,0,0,0,9, 106);
      row(0,0,0, 1,0,0,0,9, 107);

      // 2-bit error counter saturates
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if_b.i_valid = 1'b1;
         if_b.i_count = 8'(2 * i);
         @(posedge clk);
         #1;
         chk("sat_err", i, 32'(er_b), 1);
         chk("sat_cnt", i, 32'(ec_b), (i < 2) ? i + 1 : 3);
         chk("sat_sticky", i, 32'(st_b), 1);
      end
      @(negedge clk);
      if_b.i_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("sat_err_idle", 0, 32'(er_b), 0);
      chk("sat_cnt_idle", 0, 32'(ec_b), 3);

      // LOCK_CNT=1: single odd locks, odd break stays locked
      @(negedge clk);
      if_c.i_valid = 1'b1; if_c.i_count = 8'd5;
      @(posedge clk); #1;
      chk("l1_locked", 0, 32'(lk_c), 1);
      chk("l1_expected", 0, 32'(ex_c), 7);
      @(negedge clk);
      if_c.i_count = 8'd9;
      @(posedge clk); #1;
      chk("l1_locked", 1, 32'(lk_c), 1);
      chk("l1_err", 1, 32'(er_c), 1);
      chk("l1_expected", 1, 32'(ex_c), 11);
      @(negedge clk);
      if_c.i_count = 8'd11;
      @(posedge clk); #1;
      chk("l1_err", 2, 32'(er_c), 0);
      chk("l1_expected", 2, 32'(ex_c), 13);
      chk("l1_errcnt", 2, 32'(ec_c), 1);
      @(negedge clk);
      if_c.i_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
